chip_ctrl_sequencer: RTL and testbench

CHIP_CTRL_SEQUENCER -- requirements
Module: chip_ctrl_sequencer

---
 rtl/chip_ctrl_pkg.sv | 39 +++
 rtl/chip_pump_phase.sv | 61 ++++++
 rtl/chip_ctrl_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_chip_ctrl_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_ctrl_pkg.sv
// Shared types and constants for the chip valve sequencer: command opcodes,
// FSM states and the peristaltic pump step table.
package chip_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_FILL    = 2'b00,
        OP_PUMP    = 2'b01,
        OP_COLLECT = 2'b10,
        OP_FLUSH   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_CLOSE  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [2:0] STEP_LAST = 3'd5;

    // Entry 0 is the rightmost element: 100, 110, 010, 011, 001, 101.
    localparam logic [5:0][2:0] PUMP_PAT = {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

    function automatic logic [2:0] pump_pattern(input logic [2:0] idx);
        logic [2:0] pat;
        case (idx)
            3'd0:    pat = PUMP_PAT[0];
            3'd1:    pat = PUMP_PAT[1];
            3'd2:    pat = PUMP_PAT[2];
            3'd3:    pat = PUMP_PAT[3];
            3'd4:    pat = PUMP_PAT[4];
            3'd5:    pat = PUMP_PAT[5];
            default: pat = 3'b111;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/chip_pump_phase.sv
// Dwell timer and pump step index; tick_o marks the last clock of a dwell,
// wrap_o marks the last clock of the sixth step.
module chip_pump_phase
    import chip_ctrl_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               step_en_i,
    input  logic [DWELL_W-1:0] dwell_m1_i,
    output logic               tick_o,
    output logic               wrap_o,
    output logic [2:0]         step_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [2:0]         step_q, step_d;

    assign tick_o = en_i && (cnt_q == dwell_m1_i);
    assign wrap_o = tick_o && step_en_i && (step_q == STEP_LAST);
    assign step_o = step_q;

    // Next-state for dwell counter and step index; clear wins over counting.
    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        if (clr_i) begin
            cnt_d  = '0;
            step_d = 3'd0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d = '0;
                if (step_en_i) begin
                    step_d = (step_q == STEP_LAST) ? 3'd0 : step_q + 3'd1;
                end else begin
                    step_d = step_q;
                end
            end else begin
                cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d  = cnt_q;
            step_d = step_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            step_q <= 3'd0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/chip_ctrl_sequencer.sv
// Microfluidic valve sequencer: accepts FILL/PUMP/COLLECT/FLUSH commands and
// drives ring, collect, pump and flush valves through SETTLE/RUN/CLOSE.
module chip_ctrl_sequencer
    import chip_ctrl_pkg::*;
#(
    parameter int SIZE    = 7,
    parameter int CNT_W   = 8,
    parameter int DWELL_W = 16,
    localparam int CH_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [CH_W-1:0]    cmd_chan,
    input  logic [CNT_W-1:0]   cmd_count,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic [SIZE-1:0]    ctrl_ring,
    output logic [SIZE-1:0]    ctrl_collect,
    output logic [2:0]         pump,
    output logic               flush,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [CH_W:0] SIZE_V = (CH_W + 1)'(SIZE);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CH_W-1:0]    chan_q, chan_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [DWELL_W-1:0] dwell_m1_q, dwell_m1_d;
    logic               err_q, err_d;

    logic               ph_clr_s, ph_en_s, ph_step_en_s;
    logic               tick_s, wrap_s;
    logic [2:0]         step_s;
    logic               bad_chan_s;
    op_e                cmd_op_s;

    assign cmd_op_s   = op_e'(cmd_op);
    assign bad_chan_s = ((cmd_op_s == OP_FILL) || (cmd_op_s == OP_COLLECT)) &&
                        ({1'b0, cmd_chan} >= SIZE_V);
    // Any state change restarts the dwell timer and step index.
    assign ph_clr_s   = (state_d != state_q);

    chip_pump_phase #(
        .DWELL_W (DWELL_W)
    ) u_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (ph_clr_s),
        .en_i       (ph_en_s),
        .step_en_i  (ph_step_en_s),
        .dwell_m1_i (dwell_m1_q),
        .tick_o     (tick_s),
        .wrap_o     (wrap_s),
        .step_o     (step_s)
    );

    // Next-state, command latch and cycle counting.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        chan_d       = chan_q;
        count_d      = count_q;
        cycle_d      = cycle_q;
        dwell_m1_d   = dwell_m1_q;
        err_d        = 1'b0;
        ph_en_s      = 1'b0;
        ph_step_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op_s;
                    chan_d     = cmd_chan;
                    count_d    = cmd_count;
                    cycle_d    = '0;
                    dwell_m1_d = (cmd_dwell == '0) ? '0 : cmd_dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
                    if (bad_chan_s) begin
                        err_d = 1'b1;
                    end else if (cmd_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                ph_en_s = 1'b1;
                if (abort) begin
                    state_d = ST_CLOSE;
                end else if (tick_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_RUN: begin
                ph_en_s      = 1'b1;
                ph_step_en_s = 1'b1;
                if (abort) begin
                    state_d = ST_CLOSE;
                end else if (wrap_s) begin
                    if (cycle_q == count_q - {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_CLOSE;
                    end else begin
                        cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CLOSE: begin
                ph_en_s = 1'b1;
                if (tick_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLOSE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_FILL;
            chan_q     <= '0;
            count_q    <= '0;
            cycle_q    <= '0;
            dwell_m1_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            chan_q     <= chan_d;
            count_q    <= count_d;
            cycle_q    <= cycle_d;
            dwell_m1_q <= dwell_m1_d;
            err_q      <= err_d;
        end
    end

    // Valve decode from registered state; 1 = pressurised/closed.
    always_comb begin
        ctrl_ring    = '1;
        ctrl_collect = '1;
        pump         = 3'b111;
        flush        = 1'b0;
        if ((state_q == ST_SETTLE) || (state_q == ST_RUN)) begin
            case (op_q)
                OP_FILL: begin
                    for (int i = 0; i < SIZE; i++) begin
                        ctrl_ring[i] = (chan_q != CH_W'(i));
                    end
                end
                OP_COLLECT: begin
                    for (int i = 0; i < SIZE; i++) begin
                        ctrl_collect[i] = (chan_q != CH_W'(i));
                    end
                end
                OP_FLUSH: begin
                    ctrl_ring    = '0;
                    ctrl_collect = '0;
                    flush        = 1'b1;
                end
                OP_PUMP: begin
                    flush = 1'b0;
                end
                default: begin
                    flush = 1'b0;
                end
            endcase
            if (state_q == ST_RUN) begin
                pump = (op_q == OP_FLUSH) ? 3'b000 : pump_pattern(step_s);
            end else begin
                pump = 3'b111;
            end
        end else begin
            pump = 3'b111;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_chip_ctrl_sequencer.sv
// Directed self-checking bench for chip_ctrl_sequencer; each cycle compares a
// packed observation {ring, collect, pump, flush, busy, done, err, ready}.
module tb_chip_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [2:0]  cmd_chan = 3'd0;
    logic [7:0]  cmd_count = 8'd0;
    logic [15:0] cmd_dwell = 16'd0;
    logic        abort = 1'b0;
    logic [6:0]  ctrl_ring, ctrl_collect;
    logic [2:0]  pump;
    logic        flush, busy, done, err;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [2:0] pat [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    wire [21:0] obs = {ctrl_ring, ctrl_collect, pump, flush, busy, done, err, cmd_ready};

    localparam logic [21:0] IDLE_V  = {7'h7F, 7'h7F, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [21:0] CLOSE_V = {7'h7F, 7'h7F, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [21:0] DONE_V  = {7'h7F, 7'h7F, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    chip_ctrl_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_chan     (cmd_chan),
        .cmd_count    (cmd_count),
        .cmd_dwell    (cmd_dwell),
        .abort        (abort),
        .ctrl_ring    (ctrl_ring),
        .ctrl_collect (ctrl_collect),
        .pump         (pump),
        .flush        (flush),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Offer a command just after a negedge; it is accepted at the next posedge (cycle 0).
    task automatic issue(input logic [1:0] op, input logic [2:0] ch,
                         input logic [7:0] cnt, input logic [15:0] dw);
        cmd_op = op; cmd_chan = ch; cmd_count = cnt; cmd_dwell = dw;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (obs !== IDLE_V) begin
            err_cnt++;
            $display("FAIL reset_state: got %h expected %h", obs, IDLE_V);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (obs !== IDLE_V) begin
            err_cnt++;
            $display("FAIL reset_release_ready: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_fill();
        logic [21:0] e;
        issue(2'b00, 3'd3, 8'd1, 16'd2);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c <= 2)       e = {7'h77, 7'h7F, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            else if (c <= 14) e = {7'h77, 7'h7F, pat[(c-3)/2], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            else if (c <= 16) e = CLOSE_V;
            else if (c == 17) e = DONE_V;
            else              e = IDLE_V;
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL fill_cycle_%0d: got %h expected %h", c, obs, e);
            end
        end
    endtask

    task automatic test_bad_chan();
        logic [21:0] e;
        issue(2'b10, 3'd7, 8'd3, 16'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            e = (c == 1) ? {7'h7F, 7'h7F, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1} : IDLE_V;
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL bad_chan_cycle_%0d: got %h expected %h", c, obs, e);
            end
        end
    endtask

    task automatic test_zero_count();
        logic [21:0] e;
        issue(2'b01, 3'd0, 8'd0, 16'd5);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            e = (c == 1) ? DONE_V : IDLE_V;
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL zero_count_cycle_%0d: got %h expected %h", c, obs, e);
            end
        end
    endtask

    task automatic test_flush();
        logic [21:0] e;
        issue(2'b11, 3'd0, 8'd2, 16'd1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1)       e = {7'h00, 7'h00, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            else if (c <= 13) e = {7'h00, 7'h00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            else if (c == 14) e = CLOSE_V;
            else if (c == 15) e = DONE_V;
            else              e = IDLE_V;
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL flush_cycle_%0d: got %h expected %h", c, obs, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [21:0] e;
        issue(2'b01, 3'd0, 8'd3, 16'd2);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c <= 2)       e = CLOSE_V;
            else if (c <= 9)  e = {7'h7F, 7'h7F, pat[(c-3)/2], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            else if (c <= 11) e = CLOSE_V;
            else if (c == 12) e = DONE_V;
            else              e = IDLE_V;
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL abort_cycle_%0d: got %h expected %h", c, obs, e);
            end
            if (c == 9) begin
                abort = 1'b1;
                cmd_op = 2'b00; cmd_chan = 3'd1; cmd_count = 8'd1; cmd_dwell = 16'd1;
                cmd_valid = 1'b1;
            end else if (c == 10) begin
                abort = 1'b0;
            end else if (c == 12) begin
                cmd_valid = 1'b0;
            end else begin
                abort = abort;
            end
        end
    endtask

    task automatic test_abort_on_accept();
        logic [21:0] e;
        abort = 1'b1;
        issue(2'b00, 3'd0, 8'd1, 16'd1);
        abort = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            e = {7'h7E, 7'h7F, (c == 1) ? 3'b111 : 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL abort_on_accept_cycle_%0d: got %h expected %h", c, obs, e);
            end
        end
        repeat (10) @(negedge clk);
        vec_cnt++;
        if (obs !== IDLE_V) begin
            err_cnt++;
            $display("FAIL abort_on_accept_end: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [21:0] e;
        issue(2'b00, 3'd2, 8'd2, 16'd3);
        repeat (6) @(negedge clk);
        e = {7'h7B, 7'h7F, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec_cnt++;
        if (obs !== e) begin
            err_cnt++;
            $display("FAIL mid_run_before_reset: got %h expected %h", obs, e);
        end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (obs !== IDLE_V) begin
            err_cnt++;
            $display("FAIL reset_async_close: got %h expected %h", obs, IDLE_V);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs !== IDLE_V) begin
                err_cnt++;
                $display("FAIL reset_hold_%0d: got %h expected %h", c, obs, IDLE_V);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs !== IDLE_V) begin
                err_cnt++;
                $display("FAIL reset_release_%0d: got %h expected %h", c, obs, IDLE_V);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_bad_chan();
        test_zero_count();
        test_flush();
        test_abort();
        test_abort_on_accept();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
